fundamental_mode_sequencer: RTL

//   Synchronous controller for the 2-input, 2-state-bit asynchronous next-state datapath.

---
 rtl/fundamental_mode_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fundamental_mode_sequencer.sv
// Fundamental-mode sequencer for a 2-input, 2-state-bit asynchronous next-state datapath.
// Debounces buttons, applies one input change at a time and iterates y until stable.
module fundamental_mode_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned MAX_ITER        = 4
) (
    input  logic       sys_clk_in,
    input  logic       sys_rst_n,
    input  logic       btn_x2,
    input  logic       btn_x1,
    input  logic       btn_clr,
    output logic       x2_o,
    output logic       x1_o,
    output logic       y2_o,
    output logic       y1_o,
    input  logic       ny2_i,
    input  logic       ny1_i,
    input  logic       z_i,
    output logic       z_o,
    output logic       busy_o,
    output logic       err_dbl_o,
    output logic       err_osc_o,
    output logic [7:0] step_cnt_o
);

    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned StW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DbW-1:0] DbMax  = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [StW-1:0] StMax  = StW'(SETTLE_CYCLES - 1);
    localparam logic [7:0]     IterMx = 8'(MAX_ITER);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StSample,
        StErrDbl,
        StErrOsc
    } state_e;

    // Synchroniser bit order: {clr, x2, x1}
    logic [2:0] sync1_q, sync2_q;
    logic [1:0] deb;
    logic       clr;

    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_clr, btn_x2, btn_x1};
            sync2_q <= sync1_q;
        end
    end

    assign clr = sync2_q[2];

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic [DbW-1:0] cnt_q;
        logic           val_q;

        // Counter only runs while the synchronised level disagrees; any return clears it.
        always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                cnt_q <= '0;
                val_q <= 1'b0;
            end else if (sync2_q[i] == val_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DbMax) begin
                cnt_q <= '0;
                val_q <= sync2_q[i];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign deb[i] = val_q;
    end

    state_e         state_q, state_d;
    logic [1:0]     x_q, x_d;
    logic [1:0]     y_q, y_d;
    logic           z_q, z_d;
    logic [7:0]     step_q, step_d;
    logic [7:0]     iter_q, iter_d;
    logic [StW-1:0] settle_q, settle_d;
    logic           busy_q, busy_d;
    logic           err_dbl_q, err_dbl_d;
    logic           err_osc_q, err_osc_d;
    logic [1:0]     diff;
    logic [1:0]     ny;

    assign diff = deb ^ x_q;
    assign ny   = {ny2_i, ny1_i};

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        step_d   = step_q;
        iter_d   = iter_q;
        settle_d = settle_q;
        busy_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (diff == 2'b11) begin
                    state_d = StErrDbl;
                end else if (diff != 2'b00) begin
                    x_d      = deb;
                    iter_d   = '0;
                    settle_d = '0;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (settle_q == StMax) begin
                    settle_d = '0;
                    state_d  = StSample;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StSample: begin
                if (ny == y_q) begin
                    z_d     = z_i;
                    step_d  = (iter_q > IterMx) ? IterMx : iter_q;
                    state_d = StIdle;
                    // busy stays up for the cycle after the final sample
                    busy_d  = 1'b1;
                end else if (iter_q == IterMx) begin
                    state_d = StErrOsc;
                end else begin
                    y_d      = ny;
                    iter_d   = iter_q + 8'd1;
                    settle_d = '0;
                    state_d  = StSettle;
                end
            end
            StErrDbl: begin
                if (clr) begin
                    x_d     = deb;
                    state_d = StIdle;
                end
            end
            StErrOsc: begin
                if (clr) begin
                    x_d     = deb;
                    y_d     = 2'b00;
                    z_d     = 1'b0;
                    step_d  = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StSettle || state_d == StSample) begin
            busy_d = 1'b1;
        end
        err_dbl_d = (state_d == StErrDbl);
        err_osc_d = (state_d == StErrOsc);
    end

    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            x_q       <= 2'b00;
            y_q       <= 2'b00;
            z_q       <= 1'b0;
            step_q    <= '0;
            iter_q    <= '0;
            settle_q  <= '0;
            busy_q    <= 1'b0;
            err_dbl_q <= 1'b0;
            err_osc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            step_q    <= step_d;
            iter_q    <= iter_d;
            settle_q  <= settle_d;
            busy_q    <= busy_d;
            err_dbl_q <= err_dbl_d;
            err_osc_q <= err_osc_d;
        end
    end

    assign x2_o       = x_q[1];
    assign x1_o       = x_q[0];
    assign y2_o       = y_q[1];
    assign y1_o       = y_q[0];
    assign z_o        = z_q;
    assign busy_o     = busy_q;
    assign err_dbl_o  = err_dbl_q;
    assign err_osc_o  = err_osc_q;
    assign step_cnt_o = step_q;

endmodule
